seq_slice_alu: RTL

SEQ_SLICE_ALU -- requirements
Module: seq_slice_alu

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_slice.sv | 42 ++++
 rtl/seq_slice_alu.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and an opcode-class helper for the slice-serial ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASB = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice; zero latency, no flow control.
// For logic ops the carry input is ignored and both carry outputs are 0.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  input  logic [2:0]       i_s,
  output logic [SLICE-1:0] o_res,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [SLICE-1:0] w_b_eff;
  logic [SLICE:0]   w_sum;

  always_comb begin
    w_b_eff = (i_s == OP_SUB) ? ~i_b : i_b;
    w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{SLICE{1'b0}}, i_cin};
    o_res   = '0;
    o_cout  = 1'b0;
    o_cmsb  = 1'b0;
    case (i_s)
      OP_ADD, OP_SUB: begin
        o_res  = w_sum[SLICE-1:0];
        o_cout = w_sum[SLICE];
        // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly
        o_cmsb = i_a[SLICE-1] ^ w_b_eff[SLICE-1] ^ w_sum[SLICE-1];
      end
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      OP_XNOR: o_res = ~(i_a ^ i_b);
      OP_NOTA: o_res = ~i_a;
      default: o_res = i_b;
    endcase
  end

endmodule

// File: rtl/seq_slice_alu.sv
// Slice-serial ALU: result valid WIDTH/SLICE edges after accept; one op in flight at a time.
// Result holds in DONE until out_ready; in_ready only in IDLE, so no accept overlaps a pending result.
module seq_slice_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_cout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSL  = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDXW-1:0]  LAST    = IDXW'(NSL - 1);
  localparam logic [WIDTH-1:0] SL_MASK = WIDTH'({SLICE{1'b1}});

  if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("seq_slice_alu: WIDTH must be a positive multiple of SLICE");
  end

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [2:0]       r_s;
  logic             r_carry, r_cout, r_zero, r_ovf;
  logic [IDXW-1:0]  r_idx;

  logic [31:0]      w_sh;
  logic [SLICE-1:0] w_a_sl, w_b_sl, w_res;
  logic             w_cout, w_cmsb;
  logic [WIDTH-1:0] w_next_res;

  assign w_sh   = 32'(r_idx) * 32'(SLICE);
  assign w_a_sl = SLICE'(r_a >> w_sh);
  assign w_b_sl = SLICE'(r_b >> w_sh);
  assign w_next_res = (r_res & ~(SL_MASK << w_sh)) | (WIDTH'(w_res) << w_sh);

  alu_slice #(.SLICE(SLICE)) u_slice (
    .i_a    (w_a_sl),
    .i_b    (w_b_sl),
    .i_cin  (r_carry),
    .i_s    (r_s),
    .o_res  (w_res),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  // in_ready is registered so it stays low during reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= OP_ADD;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_s        <= s;
            r_carry    <= cin;
            r_idx      <= '0;
            r_res      <= '0;
            r_cout     <= 1'b0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= ST_CALC;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_CALC: begin
          r_res   <= w_next_res;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_cout      <= is_arith(r_s) & w_cout;
            r_ovf       <= is_arith(r_s) & (w_cmsb ^ w_cout);
            r_zero      <= (w_next_res == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign alu_out   = r_res;
  assign alu_cout  = r_cout;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

endmodule
